// File: rtl/z_pipe_rca.sv
// z_pipe_rca: pipelined ripple-carry adder/subtractor.
//
// The n-bit operands are cut into S chunks of W = n/S bits. Stage k ripples
// chunk k through W generate/propagate/full-adder cells, using the carry that
// stage k-1 registered. Operand chunks that have not been added yet travel
// down the pipe with their carry. Finished sum chunks travel with them as well,
// so all n sum bits leave the last stage in the same cycle.
//
// Parameters:
//   n  operand/sum width, a multiple of S
//   S  number of pipeline stages (= chunks), S >= 1
//   D  per-cell gate delay in the original model. The cells here have no
//      delay, so cycle behaviour never depends on D.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, c_in, sub)
//   a, b                operands
//   c_in                carry-in, ignored when sub=1
//   sub                 0: a + b + c_in, 1: a - b
//   out_valid/out_ready result handshake
//   sum                 result modulo 2^n
//   c_out               carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf                 two's-complement overflow
module z_pipe_rca #(
  parameter int n = 16,
  parameter int S = 4,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int W = n / S;

  generate
    if (S < 1 || (n % S) != 0 || D < 0) begin : g_bad_params
      $error("z_pipe_rca: n must be a multiple of S, S >= 1 and D >= 0");
    end
  endgenerate

  // Registers at the output of each stage.
  logic [n-1:0] a_q     [S];
  logic [n-1:0] b_q     [S];
  logic [n-1:0] sum_q   [S];
  logic         carry_q [S];
  logic         vld_q   [S];
  logic         ovf_q;

  // Inputs seen by each stage, and the values each stage computes.
  logic [n-1:0] st_a    [S];
  logic [n-1:0] st_b    [S];
  logic [n-1:0] st_sum  [S];
  logic         st_c    [S];
  logic         st_vld  [S];
  logic [n-1:0] nxt_sum [S];
  logic         nxt_c   [S];
  logic         nxt_ovf;
  logic         c;
  logic         g;
  logic         p;
  logic         c_msb;
  logic         advance;

  // A single global stall keeps every stage in step. The pipe moves whenever
  // the output slot is empty or is being drained.
  assign advance   = !vld_q[S-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[S-1];
  assign sum       = sum_q[S-1];
  assign c_out     = carry_q[S-1];
  assign ovf       = ovf_q;

  // Stage 0 takes the conditioned operands straight from the ports. Subtraction
  // is done as a + ~b + 1, so c_in is replaced by 1 in that case.
  always_comb begin
    st_a[0]   = a;
    st_b[0]   = b ^ {n{sub}};
    st_c[0]   = sub ? 1'b1 : c_in;
    st_sum[0] = '0;
    st_vld[0] = in_valid;
    for (int k = 1; k < S; k++) begin
      st_a[k]   = a_q[k-1];
      st_b[k]   = b_q[k-1];
      st_c[k]   = carry_q[k-1];
      st_sum[k] = sum_q[k-1];
      st_vld[k] = vld_q[k-1];
    end
  end

  // Each stage ripples its own chunk. The carry into the MSB cell is recorded
  // so the last stage can form the overflow flag.
  always_comb begin
    c       = 1'b0;
    g       = 1'b0;
    p       = 1'b0;
    c_msb   = 1'b0;
    nxt_ovf = 1'b0;
    for (int k = 0; k < S; k++) begin
      nxt_sum[k] = st_sum[k];
      c          = st_c[k];
      for (int i = 0; i < W; i++) begin
        g = st_a[k][k*W+i] & st_b[k][k*W+i];
        p = st_a[k][k*W+i] ^ st_b[k][k*W+i];
        nxt_sum[k][k*W+i] = p ^ c;
        if (k == S-1 && i == W-1) begin
          c_msb = c;
        end
        c = g | (p & c);
      end
      nxt_c[k] = c;
    end
    nxt_ovf = c_msb ^ nxt_c[S-1];
  end

  // Data registers load only behind a valid operation. A bubble therefore
  // leaves the last stage's sum/c_out/ovf at the most recent result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) begin
        vld_q[k]   <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < S; k++) begin
        vld_q[k] <= st_vld[k];
        if (st_vld[k]) begin
          a_q[k]     <= st_a[k];
          b_q[k]     <= st_b[k];
          sum_q[k]   <= nxt_sum[k];
          carry_q[k] <= nxt_c[k];
        end
      end
      if (st_vld[S-1]) begin
        ovf_q <= nxt_ovf;
      end
    end
  end

endmodule
